// File: rtl/conv_channel_aligner.sv
// Multi-channel column aligner: collects one column per enabled channel, then
// emits the aligned column set with a valid/ready handshake.
module conv_channel_aligner #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CHANNELS   = 4,
  parameter int COL_SIZE       = 24,
  parameter int NUM_COLS       = 24,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  input  logic [NUM_CHANNELS-1:0]                                 chan_en,
  input  logic [NUM_CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0]   col_in,
  input  logic [NUM_CHANNELS-1:0]                                 col_valid,
  output logic [NUM_CHANNELS-1:0]                                 col_ready,
  output logic [NUM_CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0]   data_out_x,
  output logic                                                    valid_out,
  input  logic                                                    out_ready,
  output logic [IDX_W-1:0]                                        col_idx,
  output logic                                                    done,
  output logic                                                    busy,
  output logic                                                    timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                                                 state_r;
  logic [NUM_CHANNELS-1:0]                                en_mask_r;
  logic [NUM_CHANNELS-1:0]                                got_r;
  logic [IDX_W-1:0]                                       col_cnt_r;
  logic [TMO_W-1:0]                                       tmo_cnt_r;
  logic [NUM_CHANNELS-1:0]                                col_ready_r;
  logic                                                   valid_out_r;
  logic                                                   done_r;
  logic                                                   busy_r;
  logic                                                   timeout_err_r;
  logic [NUM_CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0]  data_r;

  logic [NUM_CHANNELS-1:0] cap_s;
  logic [NUM_CHANNELS-1:0] got_all_s;
  logic                    last_col_s;
  logic                    tmo_hit_s;

  // Capture qualification, completion and boundary decodes.
  always_comb begin
    cap_s      = col_valid & col_ready_r;
    got_all_s  = got_r | cap_s;
    last_col_s = (col_cnt_r == IDX_W'(NUM_COLS - 1));
    // Counter only runs once the first channel of the column has landed.
    tmo_hit_s  = (got_r != '0) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  // Control FSM with registered outputs; data buffers double as data_out_x.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      en_mask_r     <= '0;
      got_r         <= '0;
      col_cnt_r     <= '0;
      tmo_cnt_r     <= '0;
      col_ready_r   <= '0;
      valid_out_r   <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      data_r        <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && (chan_en != '0)) begin
            en_mask_r     <= chan_en;
            got_r         <= '0;
            col_cnt_r     <= '0;
            tmo_cnt_r     <= '0;
            timeout_err_r <= 1'b0;
            // Disabled channels must read as zero for the whole map.
            data_r        <= '0;
            col_ready_r   <= chan_en;
            busy_r        <= 1'b1;
            state_r       <= COLLECT;
          end else begin
            state_r <= IDLE;
          end
        end

        COLLECT: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (cap_s[c]) begin
              data_r[c] <= col_in[c];
            end
          end
          got_r <= got_all_s;
          if (got_all_s == en_mask_r) begin
            col_ready_r <= '0;
            valid_out_r <= 1'b1;
            state_r     <= EMIT;
          end else if (tmo_hit_s) begin
            col_ready_r   <= '0;
            timeout_err_r <= 1'b1;
            done_r        <= 1'b1;
            state_r       <= DONE;
          end else begin
            col_ready_r <= en_mask_r & ~got_all_s;
            if (got_r != '0) begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
              tmo_cnt_r <= '0;
            end
          end
        end

        EMIT: begin
          if (out_ready) begin
            valid_out_r <= 1'b0;
            if (last_col_s) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              col_cnt_r   <= col_cnt_r + IDX_W'(1);
              got_r       <= '0;
              tmo_cnt_r   <= '0;
              col_ready_r <= en_mask_r;
              state_r     <= COLLECT;
            end
          end else begin
            state_r <= EMIT;
          end
        end

        DONE: begin
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
          col_cnt_r <= '0;
          got_r     <= '0;
          tmo_cnt_r <= '0;
          state_r   <= IDLE;
        end

        default: begin
          state_r     <= IDLE;
          col_ready_r <= '0;
          valid_out_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          col_cnt_r   <= '0;
          got_r       <= '0;
          tmo_cnt_r   <= '0;
        end
      endcase
    end
  end

  assign col_ready   = col_ready_r;
  assign data_out_x  = data_r;
  assign valid_out   = valid_out_r;
  assign col_idx     = col_cnt_r;
  assign done        = done_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: doc/conv_channel_aligner.md
CONV_CHANNEL_ALIGNER -- requirements
Module: conv_channel_aligner

Interface
REQ-001 Parameter DATA_WIDTH, default 16: FP16 element width in bits.
REQ-002 Parameter NUM_CHANNELS, default 4: number of parallel convolution channels aligned, range 1-16.
REQ-003 Parameter COL_SIZE, default 24: elements per output column.
REQ-004 Parameter NUM_COLS, default 24: columns per feature map.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles from first capture to last capture within one column.
REQ-006 Port clk, input, 1: single clock; all logic rising-edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-low.
REQ-008 Port start, input, 1: begin one feature map; sampled in IDLE only.
REQ-009 Port chan_en, input, NUM_CHANNELS: channel enable mask, latched on accepted start.
REQ-010 Port col_in, input, [NUM_CHANNELS][COL_SIZE] x DATA_WIDTH: per-channel column data.
REQ-011 Port col_valid, input, NUM_CHANNELS: per-channel column valid.
REQ-012 Port col_ready, output, NUM_CHANNELS: per-channel capture ready.
REQ-013 Port data_out_x, output, [NUM_CHANNELS][COL_SIZE] x DATA_WIDTH: aligned column set.
REQ-014 Port valid_out, output, 1: data_out_x valid.
REQ-015 Port out_ready, input, 1: downstream accept.
REQ-016 Port col_idx, output, clog2(NUM_COLS): index of column in data_out_x.
REQ-017 Port done, output, 1: one-cycle pulse at end of map.
REQ-018 Port busy, output, 1: high in any state except IDLE.
REQ-019 Port timeout_err, output, 1: sticky timeout flag, cleared on next accepted start.

Function
REQ-020 FSM states SHALL be IDLE, COLLECT, EMIT, DONE.
REQ-021 IDLE: start=1 with chan_en!=0 -> latch en_mask=chan_en, col_cnt=0, clear got mask, clear timeout_err, go COLLECT; start with chan_en=0 ignored.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 COLLECT: col_ready[c]=en_mask[c] & ~got[c]; all other states col_ready=0.
REQ-024 Capture on col_valid[c]&col_ready[c]: store col_in[c] into channel buffer c, set got[c]; multiple channels may capture in the same cycle.
REQ-025 col_valid on disabled or already-captured channel SHALL be ignored, buffer unchanged.
REQ-026 When (got | this-cycle captures) == en_mask, next state EMIT; valid_out rises the cycle after the final capture (latency 1).
REQ-027 Timeout counter: starts at 0 on first capture of a column, increments each COLLECT cycle while got != en_mask; on reaching TIMEOUT_CYCLES -> set timeout_err, go DONE without emitting.
REQ-028 EMIT: valid_out=1; data_out_x and col_idx held stable until out_ready=1.
REQ-029 data_out_x[c] SHALL be all-zero for channels with en_mask[c]=0.
REQ-030 EMIT handshake (valid_out&out_ready): if col_cnt==NUM_COLS-1 go DONE, else col_cnt+1, got=0, timeout counter=0, go COLLECT.
REQ-031 DONE: done=1 for exactly one cycle, then IDLE; col_cnt reset to 0.
REQ-032 col_idx SHALL equal col_cnt at all times; wraps only via DONE, never beyond NUM_COLS-1.
REQ-033 No arithmetic on data; data paths are pure registers, width DATA_WIDTH unchanged.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, valid_out=0, done=0, busy=0, col_ready=0, timeout_err=0, col_idx=0, got=0, en_mask=0, timeout counter=0, data_out_x=0.
REQ-035 Reset asserted mid-map SHALL abandon the map; no done pulse on or after release.
REQ-036 After rst release, block SHALL accept start on the first rising edge.

Verification
REQ-037 NUM_CHANNELS=4, chan_en=4'hF, all col_valid together each column, out_ready=1 -> 24 valid_out beats, col_idx 0..23, valid_out 1 cycle after capture, one done pulse after beat 23.
REQ-038 Skewed arrival: ch0 at t, ch3 at t+5, ch1 t+2, ch2 t+7 -> valid_out at t+8, data_out_x matches each channel's captured column, col_ready[c] drops after capture.
REQ-039 chan_en=4'b0101, col_valid on all four -> col_ready[1]=col_ready[3]=0, data_out_x[1] and [3] all-zero, emission after ch0 and ch2 only.
REQ-040 out_ready held 0 for 10 cycles in EMIT while new col_valid arrives -> data_out_x/col_idx stable, col_ready=0, no capture until handshake.
REQ-041 TIMEOUT_CYCLES=16, ch2 never valid -> timeout_err=1 at 16 cycles after first capture, done pulse, no valid_out; next start clears timeout_err.
REQ-042 rst=0 at column 10 -> all outputs at reset values same cycle, no done; subsequent start runs full 24-column map from col_idx 0.
